// File: rtl/pwm_meter_if.sv
// Measurement bus of pwm_meter: the PWM input plus the published high-time/period result.
interface pwm_meter_if #(
    parameter int unsigned CNT_BITS = 19
);
    logic                pwm_in;
    logic [CNT_BITS-1:0] high_time;
    logic [CNT_BITS-1:0] period;
    logic                valid;
    logic                stuck;

    modport master (output pwm_in, input high_time, period, valid, stuck);
    modport slave  (input pwm_in, output high_time, period, valid, stuck);
endinterface

// File: rtl/pwm_meter.sv
// PWM receiver: measures high time and period in clk cycles, one result per period,
// and reports stuck-high/stuck-low inputs after a full saturated counter span.
module pwm_meter #(
    parameter int unsigned CNT_BITS    = 19,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_meter_if.slave  bus
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        HIGH,
        LOW,
        WAIT_EDGE_S
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic                   rise;
    logic                   fall;
    logic                   timeout;

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] hi_acc_q, hi_acc_d;
    logic [CNT_BITS-1:0] high_time_q, high_time_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                stuck_q, stuck_d;

    // Input synchroniser and edge-detect flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            s_d_q  <= s;
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign fall    = ~s & s_d_q;
    // Any edge this cycle takes priority over the saturation timeout
    assign timeout = (cnt_q == CNT_MAX) && !rise && !fall;

    // State, counter and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_FIRST;
            cnt_q       <= '0;
            hi_acc_q    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_acc_q    <= hi_acc_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
        end
    end

    // Next-state, counter update and publish decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        hi_acc_d    = hi_acc_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        stuck_d     = stuck_q;

        if (rise) begin
            cnt_d = CNT_ONE;
        end

        case (state_q)
            WAIT_FIRST: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    hi_acc_d = cnt_q;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    high_time_d = hi_acc_q;
                    period_d    = cnt_q;
                    stuck_d     = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = HIGH;
                end
            end
            WAIT_EDGE_S: begin
                if (rise) state_d = HIGH;
            end
            default: state_d = WAIT_FIRST;
        endcase

        // Full span with no edge: report stuck at the current level and restart the span
        if (timeout) begin
            high_time_d = s ? CNT_MAX : '0;
            period_d    = CNT_MAX;
            stuck_d     = 1'b1;
            valid_d     = 1'b1;
            cnt_d       = CNT_ONE;
            state_d     = WAIT_EDGE_S;
        end
    end

    assign bus.high_time = high_time_q;
    assign bus.period    = period_q;
    assign bus.valid     = valid_q;
    assign bus.stuck     = stuck_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Randomised bench for pwm_meter: three counter widths share one PWM waveform and are
// compared against a timestamp-based model of the measurement rules.
module tb_pwm_meter;

    localparam int unsigned SYNC = 2;
    localparam int          NDUT = 3;

    typedef struct {
        longint hi;
        longint per;
        longint st;
        longint t;
    } pub_t;

    logic clk;
    logic rst_n;
    logic pwm;
    int   cyc;
    bit   rec;

    int n_checks;
    int n_errors;

    bit     stim[$];
    pub_t   exp_q[NDUT][$];
    pub_t   obs_q[NDUT][$];
    longint maxv[NDUT];

    pwm_meter_if #(.CNT_BITS(8))  if8  ();
    pwm_meter_if #(.CNT_BITS(4))  if4  ();
    pwm_meter_if #(.CNT_BITS(19)) if19 ();

    assign if8.pwm_in  = pwm;
    assign if4.pwm_in  = pwm;
    assign if19.pwm_in = pwm;

    pwm_meter #(.CNT_BITS(8),  .SYNC_STAGES(SYNC)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    pwm_meter #(.CNT_BITS(4),  .SYNC_STAGES(SYNC)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    pwm_meter #(.CNT_BITS(19), .SYNC_STAGES(SYNC)) u_dut19 (.clk(clk), .rst_n(rst_n), .bus(if19.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every published result with the cycle it appeared in
    always @(negedge clk) begin
        if (rec) begin
            if (if8.valid)  obs_q[0].push_back('{longint'(if8.high_time),  longint'(if8.period),  longint'(if8.stuck),  longint'(cyc)});
            if (if4.valid)  obs_q[1].push_back('{longint'(if4.high_time),  longint'(if4.period),  longint'(if4.stuck),  longint'(cyc)});
            if (if19.valid) obs_q[2].push_back('{longint'(if19.high_time), longint'(if19.period), longint'(if19.stuck), longint'(cyc)});
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input bit b);
        @(posedge clk);
        #1 pwm = b;
    endtask

    task automatic add_pulse(input int h, input int l);
        for (int i = 0; i < h; i++) stim.push_back(1'b1);
        for (int i = 0; i < l; i++) stim.push_back(1'b0);
    endtask

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    // Rules on the input waveform: each sample index is one clk cycle of the synchronised level.
    // mode: 0 waiting for first rise, 1 high, 2 low, 3 stuck
    task automatic model_run(input int d);
        int     mode;
        int     ref_t;
        longint hi;
        bit     prev;
        bit     cur;
        mode  = 0;
        ref_t = 0;
        hi    = 0;
        prev  = 1'b0;
        for (int t = 0; t < stim.size(); t++) begin
            cur = stim[t];
            if (cur && !prev) begin
                if (mode == 2) exp_q[d].push_back('{hi, sat(longint'(t - ref_t), maxv[d]), 0, longint'(t)});
                mode  = 1;
                ref_t = t;
            end else if (!cur && prev) begin
                if (mode == 1) begin
                    hi   = sat(longint'(t - ref_t), maxv[d]);
                    mode = 2;
                end
            end else if (mode != 0 && longint'(t - ref_t) >= maxv[d]) begin
                exp_q[d].push_back('{cur ? maxv[d] : 0, maxv[d], 1, longint'(t)});
                ref_t = t;
                mode  = 3;
            end
            prev = cur;
        end
    endtask

    function automatic longint out_hi(input int d);
        case (d)
            0:       return longint'(if8.high_time);
            1:       return longint'(if4.high_time);
            default: return longint'(if19.high_time);
        endcase
    endfunction

    function automatic longint out_per(input int d);
        case (d)
            0:       return longint'(if8.period);
            1:       return longint'(if4.period);
            default: return longint'(if19.period);
        endcase
    endfunction

    initial begin
        string tg;
        int    nmin;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rec      = 1'b0;
        pwm      = 1'b0;
        rst_n    = 1'b0;
        maxv[0]  = 255;
        maxv[1]  = 15;
        maxv[2]  = 524287;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // A few periods, then reset in the middle of a high phase
        repeat (3) drive_bit(1'b0);
        for (int p = 0; p < 3; p++) begin
            repeat (3) drive_bit(1'b1);
            repeat (5) drive_bit(1'b0);
        end
        repeat (5) drive_bit(1'b1);
        @(negedge clk);
        check("pre_rst_period8", longint'(if8.period), 8);
        check("pre_rst_high8", longint'(if8.high_time), 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        pwm = 1'b0;
        #1;
        check("rst_high8",   longint'(if8.high_time),  0);
        check("rst_period8", longint'(if8.period),     0);
        check("rst_valid8",  longint'(if8.valid),      0);
        check("rst_stuck8",  longint'(if8.stuck),      0);
        check("rst_high4",   longint'(if4.high_time),  0);
        check("rst_period4", longint'(if4.period),     0);
        check("rst_valid4",  longint'(if4.valid),      0);
        check("rst_stuck4",  longint'(if4.stuck),      0);
        check("rst_high19",  longint'(if19.high_time), 0);
        check("rst_period19",longint'(if19.period),    0);
        check("rst_valid19", longint'(if19.valid),     0);
        check("rst_stuck19", longint'(if19.stuck),     0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Waveform: steady, duty change, saturation boundaries, random, stuck low/high, loopback
        for (int i = 0; i < 4; i++) stim.push_back(1'b0);
        for (int p = 0; p < 6; p++) add_pulse(3, 5);
        for (int p = 0; p < 4; p++) add_pulse(6, 2);
        add_pulse(7, 8);
        add_pulse(8, 8);
        add_pulse(3, 5);
        for (int p = 0; p < 20; p++) add_pulse(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
        add_pulse(3, 5);
        add_pulse(3, 40);
        for (int p = 0; p < 3; p++) add_pulse(3, 5);
        add_pulse(35, 3);
        for (int p = 0; p < 3; p++) add_pulse(2, 4);
        // 8-bit free-running generator at duty 64
        for (int i = 0; i < 3 * 256; i++) stim.push_back((i % 256) < 64);
        add_pulse(2, 2);
        add_pulse(2, 6);

        for (int d = 0; d < NDUT; d++) model_run(d);

        rec = 1'b1;
        for (int i = 0; i < stim.size(); i++) drive_bit(stim[i]);
        repeat (8) drive_bit(1'b0);
        @(negedge clk);
        rec = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            $sformat(tg, "count_d%0d", d);
            check(tg, longint'(obs_q[d].size()), longint'(exp_q[d].size()));
            nmin = (obs_q[d].size() < exp_q[d].size()) ? obs_q[d].size() : exp_q[d].size();
            for (int i = 0; i < nmin; i++) begin
                $sformat(tg, "high_d%0d_%0d", d, i);
                check(tg, obs_q[d][i].hi, exp_q[d][i].hi);
                $sformat(tg, "period_d%0d_%0d", d, i);
                check(tg, obs_q[d][i].per, exp_q[d][i].per);
                $sformat(tg, "stuck_d%0d_%0d", d, i);
                check(tg, obs_q[d][i].st, exp_q[d][i].st);
                if (i > 0) begin
                    $sformat(tg, "spacing_d%0d_%0d", d, i);
                    check(tg, obs_q[d][i].t - obs_q[d][i-1].t, exp_q[d][i].t - exp_q[d][i-1].t);
                end
            end
            if (exp_q[d].size() > 0) begin
                $sformat(tg, "hold_high_d%0d", d);
                check(tg, out_hi(d), exp_q[d][exp_q[d].size()-1].hi);
                $sformat(tg, "hold_period_d%0d", d);
                check(tg, out_per(d), exp_q[d][exp_q[d].size()-1].per);
            end
        end

        if (obs_q[0].size() > 0) begin
            check("first_high8", obs_q[0][0].hi, 3);
            check("first_period8", obs_q[0][0].per, 8);
        end else begin
            check("first_pub8_present", 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
